// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus/memory geometry, FSM state encoding
// and the transfer record latched at the setup phase.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned APB_MEM_DEPTH  = 256;
    // Largest supported word index width; MEM_DEPTH may not exceed 2**APB_IDX_MAX_W.
    localparam int unsigned APB_IDX_MAX_W  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    typedef struct packed {
        logic                     write;
        logic [APB_IDX_MAX_W-1:0] idx;
        logic                     err;
    } apb_xfer_t;

endpackage

// File: rtl/apb_slave_mem_array.sv
// Word-addressed register memory: synchronous write, combinational read,
// asynchronous clear to zero on reset.
module apb_slave_mem_array
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH  = APB_MEM_DEPTH,
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with internal register memory and configurable wait states.
// Define APB_SLAVE_SLVERR_EN to report out-of-range/misaligned accesses via PSLVERR.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH   = APB_MEM_DEPTH,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    apb_state_e            state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    apb_xfer_t             xfer_q, xfer_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [IDX_W-1:0]      req_idx;
    logic                  req_err;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_bits;

    assign req_idx = PADDR[IDX_W+1:2];

`ifdef APB_SLAVE_SLVERR_EN
    assign req_err = (64'(PADDR) >= 64'(MEM_DEPTH) * 64'd4) || (PADDR[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    // Only the low word-index bits of PADDR and of the latched index matter here.
    assign unused_bits = ^{PADDR, xfer_q.idx};

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        xfer_d     = xfer_q;
        prdata_d   = prdata_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSELx && !PENABLE) begin
                    state_d      = ACCESS;
                    wait_cnt_d   = 4'(WAIT_STATES);
                    xfer_d.write = PWRITE;
                    xfer_d.err   = req_err;
                    xfer_d.idx   = '0;
                    xfer_d.idx[IDX_W-1:0] = req_idx;
                    if (!PWRITE) begin
                        prdata_d = req_err ? '0 : mem_rdata;
                    end
                end
            end
            ACCESS: begin
                if (!PSELx) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else if (PENABLE) begin
                    state_d = IDLE;
                    mem_we  = xfer_q.write && !xfer_q.err;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            xfer_q     <= '0;
            prdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            xfer_q     <= xfer_d;
            prdata_q   <= prdata_d;
        end
    end

    apb_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (mem_we),
        .waddr (xfer_q.idx[IDX_W-1:0]),
        .wdata (PWDATA),
        .raddr (req_idx),
        .rdata (mem_rdata)
    );

    assign PRDATA = prdata_q;
    assign PREADY = (state_q == ACCESS) && (wait_cnt_q == 4'd0);

`ifdef APB_SLAVE_SLVERR_EN
    assign PSLVERR = PREADY && xfer_q.err;
`else
    assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: a WAIT_STATES=0 instance and a WAIT_STATES=3 instance
// share the clock and reset; expected responses are queued and checked at PREADY.
module tb_apb_slave_mem;

`ifdef APB_SLAVE_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int tests  = 0;
    int failed = 0;
    int cyc_cnt = 0;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          wr;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    apb_slave_mem #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (256), .WAIT_STATES (0)
    ) u_dut0 (
        .PCLK (clk), .PRESETn (rst_n), .PSELx (psel[0]), .PENABLE (penable[0]),
        .PWRITE (pwrite[0]), .PADDR (paddr[0]), .PWDATA (pwdata[0]),
        .PRDATA (prdata[0]), .PREADY (pready[0]), .PSLVERR (pslverr[0])
    );

    apb_slave_mem #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (256), .WAIT_STATES (3)
    ) u_dut1 (
        .PCLK (clk), .PRESETn (rst_n), .PSELx (psel[1]), .PENABLE (penable[1]),
        .PWRITE (pwrite[1]), .PADDR (paddr[1]), .PWDATA (pwdata[1]),
        .PRDATA (prdata[1]), .PREADY (pready[1]), .PSLVERR (pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input int d, input int ws, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        int   cyc;
        bit   ready;
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
        pwdata[d] = ~wdata;
        sbq.push_back('{rdata: exp_rd, err: exp_err, wr: wr});
        @(negedge clk);
        penable[d] = 1'b1; pwdata[d] = wdata;
        cyc = 1; ready = 1'b0;
        while (cyc <= 40) begin
            if (pready[d]) begin
                ready = 1'b1;
                break;
            end
            check("pslverr_idle", 32'(pslverr[d]), 32'd0);
            if (!wr) check("rd_stable", prdata[d], exp_rd);
            @(negedge clk);
            cyc++;
        end
        e = sbq.pop_front();
        if (!ready) begin
            check("pready_timeout", 32'd0, 32'd1);
            return;
        end
        check("access_cycles", 32'(cyc), 32'(ws + 1));
        check("pslverr", 32'(pslverr[d]), 32'(e.err));
        if (!e.wr) check("prdata", prdata[d], e.rdata);
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        psel[d] = 1'b0; penable[d] = 1'b0;
        @(negedge clk);
        check("pready_one_cycle", 32'(pready[d]), 32'd0);
        check("pslverr_after", 32'(pslverr[d]), 32'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] v10;
        int          c0;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] v10;
        int          c0;

        vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        32'hDEADBEEF,  1'b0});
        vecs.push_back('{1'b1, 32'h14,  32'h0BADF00D, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h14,  32'h0,        32'h0BADF00D,  1'b0});
        vecs.push_back('{1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D,  1'b0});
        vecs.push_back('{1'b1, 32'h400, 32'hA5A5A5A5, 32'h0,         SLVERR_EN});
        vecs.push_back('{1'b1, 32'h13,  32'h5A5A5A5A, 32'h0,         SLVERR_EN});
        vecs.push_back('{1'b0, 32'h0,   32'h0,        SLVERR_EN ? 32'h0 : 32'hA5A5A5A5, 1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        SLVERR_EN ? 32'hDEADBEEF : 32'h5A5A5A5A, 1'b0});
        vecs.push_back('{1'b0, 32'h400, 32'h0,        SLVERR_EN ? 32'h0 : 32'hA5A5A5A5, SLVERR_EN});
        v10 = SLVERR_EN ? 32'hDEADBEEF : 32'h5A5A5A5A;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_prdata", prdata[d], 32'h0);
            check("rst_pready", 32'(pready[d]), 32'd0);
            check("rst_pslverr", 32'(pslverr[d]), 32'd0);
        end
        rst_n = 1'b1;

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            xfer(0, 0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        end
        idle(0);

        // Setup-less access phase in IDLE must be ignored.
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 32'h10; pwdata[0] = 32'hFFFFFFFF;
        repeat (2) begin
            @(negedge clk);
            check("violation_pready", 32'(pready[0]), 32'd0);
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        xfer(0, 0, 1'b0, 32'h10, 32'h0, v10, 1'b0);
        idle(0);

        // Four back-to-back writes then readback.
        c0 = cyc_cnt;
        for (int i = 0; i < 4; i++) begin
            xfer(0, 0, 1'b1, 32'(i * 4), 32'h1000 + 32'(i), 32'h0, 1'b0);
        end
        check("b2b_cycles", 32'(cyc_cnt - c0), 32'd8);
        for (int i = 0; i < 4; i++) begin
            xfer(0, 0, 1'b0, 32'(i * 4), 32'h0, 32'h1000 + 32'(i), 1'b0);
        end
        idle(0);

        xfer(1, 3, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0);
        xfer(1, 3, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);
        idle(1);

        // Abort a waited write by dropping PSELx.
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h8; pwdata[1] = 32'h77;
        @(negedge clk);
        penable[1] = 1'b1;
        check("abort_pready0", 32'(pready[1]), 32'd0);
        @(negedge clk);
        check("abort_pready1", 32'(pready[1]), 32'd0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_ready", 32'(pready[1]), 32'd0);
        end
        xfer(1, 3, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);

        // Reset during the wait state of a write.
        xfer(1, 3, 1'b1, 32'h4, 32'h11, 32'h0, 1'b0);
        xfer(1, 3, 1'b0, 32'h4, 32'h0, 32'h11, 1'b0);
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h4; pwdata[1] = 32'h22;
        @(negedge clk);
        penable[1] = 1'b1;
        @(negedge clk);
        check("pre_rst_prdata", prdata[1], 32'h11);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_prdata", prdata[1], 32'h0);
        check("midrst_pready", 32'(pready[1]), 32'd0);
        check("midrst_pslverr", 32'(pslverr[1]), 32'd0);
        @(negedge clk);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 3, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
        xfer(1, 3, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        idle(1);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
